// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared width, bubble instruction and fetch state encoding
package fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// fetch_unit_if_id_reg: IF/ID register (instr/pc in; hold freezes, bubble inserts NOP_WORD and clears id_valid, bubble wins)
module fetch_unit_if_id_reg import fetch_unit_pkg::*; #(
  parameter logic [XLEN-1:0] NOP_WORD = NOP_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            bubble,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus1,
  output logic            id_valid
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      id_instr    <= NOP_WORD;
      id_pc       <= '0;
      id_pc_plus1 <= '0;
      id_valid    <= 1'b0;
    end else if (bubble) begin
      id_instr <= NOP_WORD;
      id_valid <= 1'b0;
    end else if (!hold) begin
      id_instr    <= instr;
      id_pc       <= pc;
      id_pc_plus1 <= pc + 1'b1;
      id_valid    <= 1'b1;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, next-PC mux, fetch-fault check and BOOT/RUN/HALT control driving imem_addr and the IF/ID register
module fetch_unit import fetch_unit_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     MEM_DEPTH = 256,
  parameter logic [XLEN-1:0] NOP_WORD  = NOP_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus1,
  output logic            id_valid,
  output logic            fault
);
  state_t state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic run, flt, bubble, hold;
  assign run       = state == RUN;
  assign flt       = pc >= XLEN'(MEM_DEPTH);
  assign imem_addr = pc;
  assign fault     = state == HALT;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  always_comb begin
    state_nxt = state == BOOT ? RUN : (run && flt) ? HALT : state;
    pc_nxt    = (!run || flt) ? pc : branch_taken ? branch_target : jump ? jump_target : stall ? pc : pc + 1'b1;
    bubble    = run && (flt || branch_taken || jump || flush);
    hold      = !run || stall;
  end
  fetch_unit_if_id_reg #(.NOP_WORD(NOP_WORD)) u_if_id (
    .clk(clk), .reset(reset), .hold(hold), .bubble(bubble),
    .instr(imem_instr), .pc(pc),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus1(id_pc_plus1), .id_valid(id_valid)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with an expectation queue checked by an independent monitor
module tb_fetch_unit;
  localparam logic [31:0] H = 32'h1000_0000;
  logic clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic [31:0] imem_addr, imem_instr, id_instr, id_pc, id_pc_plus1;
  logic id_valid, fault;
  int errors = 0, checks = 0, sid = 0;
  typedef struct {int id; logic [31:0] pc, instr, idpc, p1; logic v, f;} exp_t;
  exp_t q[$];
  assign imem_instr = H + imem_addr;
  always #5 clk = ~clk;
  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus1(id_pc_plus1),
    .id_valid(id_valid), .fault(fault)
  );
  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, id, act, exp);
    end
  endtask
  task automatic chk_all(input exp_t e);
    chk("pc", e.id, imem_addr, e.pc);
    chk("id_instr", e.id, id_instr, e.instr);
    chk("id_pc", e.id, id_pc, e.idpc);
    chk("id_pc_plus1", e.id, id_pc_plus1, e.p1);
    chk("id_valid", e.id, {31'b0, id_valid}, {31'b0, e.v});
    chk("fault", e.id, {31'b0, fault}, {31'b0, e.f});
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) chk_all(q.pop_front());
  end
  task automatic step(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt,
                      input logic [31:0] pc_e, input logic [31:0] in_e, input logic [31:0] idpc_e,
                      input logic [31:0] p1_e, input logic v_e, input logic f_e);
    stall = st; flush = fl; branch_taken = br; branch_target = bt; jump = jp; jump_target = jt;
    sid++;
    q.push_back('{sid, pc_e, in_e, idpc_e, p1_e, v_e, f_e});
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    #12;
    chk_all('{0, 0, 0, 0, 0, 1'b0, 1'b0});
    @(negedge clk) reset = 1'b0;
    step(0,0,0,0,0,0,   0, 0,      0,   0,   0, 0);
    step(0,0,0,0,0,0,   1, H+0,    0,   1,   1, 0);
    step(0,0,0,0,0,0,   2, H+1,    1,   2,   1, 0);
    step(0,0,0,0,0,0,   3, H+2,    2,   3,   1, 0);
    step(1,0,0,0,0,0,   3, H+2,    2,   3,   1, 0);
    step(1,0,0,0,0,0,   3, H+2,    2,   3,   1, 0);
    step(0,0,0,0,0,0,   4, H+3,    3,   4,   1, 0);
    step(0,0,0,0,0,0,   5, H+4,    4,   5,   1, 0);
    step(0,0,1,8,1,20,  8, 0,      4,   5,   0, 0);
    step(0,0,0,0,0,0,   9, H+8,    8,   9,   1, 0);
    step(0,0,0,0,1,5,   5, 0,      8,   9,   0, 0);
    step(0,0,0,0,0,0,   6, H+5,    5,   6,   1, 0);
    step(1,1,0,0,0,0,   6, 0,      5,   6,   0, 0);
    step(0,1,0,0,0,0,   7, 0,      5,   6,   0, 0);
    step(1,0,1,10,0,0,  10, 0,     5,   6,   0, 0);
    step(0,0,0,0,0,0,   11, H+10,  10,  11,  1, 0);
    step(0,0,0,0,1,255, 255, 0,    10,  11,  0, 0);
    step(0,0,0,0,0,0,   256, H+255, 255, 256, 1, 0);
    step(0,0,0,0,0,0,   256, 0,    255, 256, 0, 1);
    step(0,0,1,3,0,0,   256, 0,    255, 256, 0, 1);
    step(1,1,0,0,1,1,   256, 0,    255, 256, 0, 1);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    step(0,0,0,0,0,0,   0, 0,      0,   0,   0, 0);
    step(0,0,0,0,1,9,   9, 0,      0,   0,   0, 0);
    step(0,0,0,0,0,0,   10, H+9,   9,   10,  1, 0);
    #2 reset = 1'b1;
    #1 chk_all('{100, 0, 0, 0, 0, 1'b0, 1'b0});
    @(negedge clk) reset = 1'b0;
    step(0,0,0,0,0,0,   0, 0,      0,   0,   0, 0);
    step(0,0,0,0,0,0,   1, H+0,    0,   1,   1, 0);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the instruction memory and feeding the decode stage. Holds the program counter and drives the word address into the instruction memory. Captures the returned instruction into an IF/ID pipeline register. Handles stall, flush, branch/jump redirect and an out-of-range fetch fault.

Parameters:
RESET_PC, 0, word address loaded into the PC on reset.
MEM_DEPTH, 256, number of instruction words; a PC at or above this value is a fetch fault.
NOP_WORD, 32'h00000000, instruction value inserted into IF/ID on a bubble.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
stall  input  1  hazard hold; freezes the PC and IF/ID.
flush  input  1  squash the IF/ID contents on the next edge.
branch_taken  input  1  branch redirect request.
branch_target  input  32  word address for a branch redirect.
jump  input  1  jump redirect request.
jump_target  input  32  word address for a jump redirect.
imem_addr  output  32  word address to the instruction memory; combinationally equal to pc.
imem_instr  input  32  instruction word returned combinationally by the memory.
id_instr  output  32  IF/ID instruction.
id_pc  output  32  IF/ID word address of the instruction.
id_pc_plus1  output  32  id_pc + 1.
id_valid  output  1  IF/ID contents are a real instruction.
fault  output  1  sticky out-of-range fetch indication.

Behaviour:
- Addressing: the PC counts in words. Sequential next PC is pc+1, modulo 2^32.
- Reset, asynchronous:
  - pc=RESET_PC, state=BOOT.
  - id_instr=NOP_WORD, id_pc=0, id_pc_plus1=0, id_valid=0, fault=0.
  - Reset asserted mid-operation discards everything immediately.
- State BOOT:
  - Lasts exactly one edge after reset release.
  - On that edge: state goes to RUN; PC and IF/ID are unchanged; id_valid stays 0.
  - stall, flush and redirects are ignored in BOOT.
- State RUN, per edge, highest priority first:
  1. Fault: if pc >= MEM_DEPTH, go to HALT; fault<=1; id_valid<=0; id_instr<=NOP_WORD; pc holds.
  2. Redirect: if branch_taken, pc<=branch_target. Otherwise, if jump, pc<=jump_target. Branch beats jump when both are asserted. In both cases the IF/ID gets a bubble (id_valid<=0, id_instr<=NOP_WORD), and this applies even when stall=1.
  3. Flush: the IF/ID gets a bubble. The PC advances to pc+1 unless stall=1, in which case the PC holds.
  4. Stall: pc and all IF/ID outputs hold their values.
  5. Normal: id_instr<=imem_instr, id_pc<=pc, id_pc_plus1<=pc+1, id_valid<=1, pc<=pc+1.
- State HALT:
  - Sticky until reset; all inputs are ignored.
  - pc holds, id_valid=0, fault=1.
- Redirect to an out-of-range target: the PC loads it; the fault is taken on the following edge.
- Latency: an instruction at address A appears on id_instr one edge after pc==A, with id_valid=1.
- imem_addr is always pc, including in BOOT and HALT. The memory is read combinationally, with no extra wait state.
- On a bubble, id_pc and id_pc_plus1 hold their previous values; only id_valid and id_instr change.

Decomposition:
- Shared package holds:
  - State encoding: BOOT=2'd0, RUN=2'd1, HALT=2'd2.
  - NOP_WORD default.
  - Instruction/address width constant, 32.
- Natural sub-module: if_id_reg. It holds the pipeline register with hold and bubble controls.
- fetch_unit keeps the PC, the next-PC mux, the fault compare and the state machine.

Test Plan:
- Reset, release, 4 edges, imem returning 32'h1000_0000+addr -> the BOOT edge shows id_valid=0 and pc=0. The next edges give id_instr 32'h10000000, 32'h10000001, 32'h10000002, each with id_valid=1 and id_pc 0, 1, 2.
- stall=1 for 2 edges at pc=3 -> pc stays 3 and IF/ID unchanged. On release, id_pc=3 on the next edge.
- branch_taken=1 with branch_target=8 and jump=1 with jump_target=20, same cycle, pc=5 -> pc=8 and id_valid=0. Next edge gives id_pc=8.
- flush=1 together with stall=1 at pc=6 -> id_valid=0, id_instr=0, pc stays 6.
- jump_target=255 then run -> id_pc=255 is captured, then pc=256 triggers fault=1 and HALT. A later branch_taken=1 leaves pc=256.
- Assert reset asynchronously mid-run at pc=10 -> outputs clear immediately, without waiting for a clock edge, and pc=0.
